// File: rtl/seg_pkg.sv
// Shared constants for the common-anode 7-segment display blocks.
// Segment codes are active-low, bit order DP,G,F,E,D,C,B,A.
package seg_pkg;
  localparam int NUM_DIG = 8;
  localparam int DP_BIT  = 7;

  localparam logic [7:0] SEG_0 = 8'hC0, SEG_1 = 8'hF9, SEG_2 = 8'hA4, SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99, SEG_5 = 8'h92, SEG_6 = 8'h82, SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80, SEG_9 = 8'h90, SEG_A = 8'h88, SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6, SEG_D = 8'hA1, SEG_E = 8'h86, SEG_F = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic [NUM_DIG-1:0][3:0] data;
    logic [NUM_DIG-1:0]      dp;
    logic [NUM_DIG-1:0]      en;
    logic                    lz;
  } disp_cfg_t;
endpackage

// File: rtl/hex_to_caseg.sv
// Combinational hex nibble to active-low segment decoder, DP left off.
module hex_to_caseg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed display scan scheduler. New content is staged in a
// pending buffer and only swapped in at the DIG_7 -> DIG_0 wrap.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL     = 50000,
  parameter int BLANK_CYC = 500,
  parameter int CNT_W     = 16
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  load_en,
  input  logic        load_lz,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [7:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_tick
);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  disp_cfg_t          act_q, act_d, pend_q, pend_d, load_cfg;
  logic               pvld_q, pvld_d;
  logic               ready_q, frame_q;
  logic [7:0]         sel_q, sel_d, seg_q, seg_d;
  logic [7:0]         seg_raw, seg_dig;
  logic [NUM_DIG-1:0] zero_hi;
  logic               tick, wrap, accept, blank;

  assign load_cfg = '{data: load_data, dp: load_dp, en: load_en, lz: load_lz};
  assign tick     = (cnt_q == CNT_W'(DWELL - 1));
  assign wrap     = tick && (idx_q == 3'(NUM_DIG - 1));
  assign accept   = load_valid && ready_q;
  assign blank    = (cnt_q < CNT_W'(BLANK_CYC));

  // zero_hi[n]: every nibble from n up to the top digit is zero
  for (genvar n = 0; n < NUM_DIG; n++) begin : g_lz
    assign zero_hi[n] = ((act_q.data >> (4 * n)) == '0);
  end

  hex_to_caseg u_dec (
    .nib_i (act_q.data[idx_q]),
    .seg_o (seg_raw)
  );

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d  = tick ? idx_q + 3'd1 : idx_q;
    act_d  = act_q;
    pend_d = pend_q;
    pvld_d = pvld_q;
    if (accept) begin
      pend_d = load_cfg;
      pvld_d = 1'b1;
    end
    // A load landing on the wrap edge with nothing staged goes straight live
    if (wrap) begin
      if (pvld_q)      act_d = pend_q;
      else if (accept) act_d = load_cfg;
      pvld_d = 1'b0;
    end
  end

  always_comb begin
    seg_dig = seg_raw;
    if (!act_q.en[idx_q] || (act_q.lz && idx_q != 3'd0 && zero_hi[idx_q]))
      seg_dig = SEG_BLANK;
    if (act_q.en[idx_q] && act_q.dp[idx_q])
      seg_dig[DP_BIT] = 1'b0;
    sel_d = blank ? '0 : (NUM_DIG'(1) << idx_q);
    seg_d = blank ? SEG_BLANK : seg_dig;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      pend_q  <= '0;
      pvld_q  <= 1'b0;
      ready_q <= 1'b1;
      frame_q <= 1'b0;
      sel_q   <= '0;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      pvld_q  <= pvld_d;
      ready_q <= !pvld_d;
      frame_q <= wrap;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign load_ready = ready_q;
  assign frame_tick = frame_q;
  assign sel        = sel_q;
  assign seg        = seg_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed + random bench for seg_scan_ctrl against a cycle-position model.
module tb_seg_scan_ctrl;
  localparam int DW = 8, BC = 2, FRAME = DW * 8;

  logic        sclk = 1'b0, rst;
  logic [31:0] load_data;
  logic [7:0]  load_dp, load_en;
  logic        load_lz, load_valid;
  logic        load_ready, frame_tick;
  logic [7:0]  sel, seg;

  always #5 sclk = ~sclk;

  seg_scan_ctrl #(.DWELL(DW), .BLANK_CYC(BC), .CNT_W(4)) dut (
    .sclk(sclk), .rst(rst), .load_data(load_data), .load_dp(load_dp),
    .load_en(load_en), .load_lz(load_lz), .load_valid(load_valid),
    .load_ready(load_ready), .sel(sel), .seg(seg), .frame_tick(frame_tick)
  );

  int n_tests = 0, n_fail = 0;

  // model: active content, staged content, edges since reset release
  logic [31:0] m_data, p_data;
  logic [7:0]  m_dp, m_en, p_dp, p_en;
  logic        m_lz, p_lz, m_pend, m_acc;
  int          t;
  logic [7:0]  seen [8];
  logic [7:0]  tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic logic [7:0] ref_seg(int n);
    logic [7:0] s;
    logic [3:0] nib;
    if (!m_en[n]) return 8'hFF;
    nib = 4'(m_data >> (4 * n));
    s = (m_lz && n != 0 && (m_data >> (4 * n)) == 0) ? 8'hFF : tbl[nib];
    if (m_dp[n]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_dp = '0; m_en = '0; m_lz = 1'b0;
    p_data = '0; p_dp = '0; p_en = '0; p_lz = 1'b0;
    m_pend = 1'b0; m_acc = 1'b0; t = 0;
  endtask

  task automatic step();
    int cnt, idx;
    logic wrap;
    logic [7:0] e_sel, e_seg;
    logic e_ft;
    m_acc = 1'b0;
    if (rst) begin
      model_reset();
      e_sel = '0; e_seg = 8'hFF; e_ft = 1'b0;
    end else begin
      cnt   = t % DW;
      idx   = (t / DW) % 8;
      e_sel = (cnt < BC) ? 8'h00 : 8'(1 << idx);
      e_seg = (cnt < BC) ? 8'hFF : ref_seg(idx);
      wrap  = (t % FRAME) == FRAME - 1;
      e_ft  = wrap;
      m_acc = load_valid && !m_pend;
      if (wrap) begin
        if (m_pend) begin
          m_data = p_data; m_dp = p_dp; m_en = p_en; m_lz = p_lz;
        end else if (m_acc) begin
          m_data = load_data; m_dp = load_dp; m_en = load_en; m_lz = load_lz;
        end
        m_pend = 1'b0;
      end else if (m_acc) begin
        p_data = load_data; p_dp = load_dp; p_en = load_en; p_lz = load_lz;
        m_pend = 1'b1;
      end
      t++;
    end
    @(posedge sclk); #1;
    chk("sel", sel, e_sel);
    chk("seg", seg, e_seg);
    chk("frame_tick", frame_tick, e_ft);
    chk("load_ready", load_ready, !m_pend);
    chk("sel_onehot", ($countones(sel) <= 1), 1);
    for (int n = 0; n < 8; n++) if (sel == 8'(1 << n)) seen[n] = seg;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic to_wrap();
    while (t % FRAME != FRAME - 1) step();
  endtask

  task automatic do_load(logic [31:0] d, logic [7:0] dp, logic [7:0] en, logic lz);
    int k;
    load_data = d; load_dp = dp; load_en = en; load_lz = lz; load_valid = 1'b1;
    k = 0;
    do begin step(); k++; end while (!m_acc && k < 200);
    if (!m_acc) chk("load_timeout", 0, 1);
    load_valid = 1'b0;
  endtask

  task automatic clr_seen();
    for (int n = 0; n < 8; n++) seen[n] = 8'h55;
  endtask

  initial begin
    int first;
    logic [7:0] exp2 [8];
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_dp = '0; load_en = '0; load_lz = 1'b0;
    model_reset();

    // 1: reset and dark display, first frame_tick 64 cycles after release
    run(3);
    chk("rst_sel", sel, 8'h00);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_ready", load_ready, 1);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 70; i++) begin
      step();
      if (frame_tick && first == 0) first = i;
    end
    chk("first_frame", first, 64);

    // 2: basic load, one full scan of 0..7
    do_load(32'h7654_3210, 8'h00, 8'hFF, 1'b0);
    to_wrap(); step(); clr_seen(); run(FRAME);
    exp2 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    for (int n = 0; n < 8; n++) chk($sformatf("basic_dig%0d", n), seen[n], exp2[n]);

    // 3: leading-zero suppression with DP on a lit digit
    do_load(32'h0000_0120, 8'h04, 8'hFF, 1'b1);
    to_wrap(); step(); clr_seen(); run(FRAME);
    exp2 = '{8'hC0, 8'hA4, 8'h79, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int n = 0; n < 8; n++) chk($sformatf("lz_dig%0d", n), seen[n], exp2[n]);
    do_load(32'h0, 8'h00, 8'hFF, 1'b1);
    to_wrap(); step(); clr_seen(); run(FRAME);
    exp2 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int n = 0; n < 8; n++) chk($sformatf("lz0_dig%0d", n), seen[n], exp2[n]);

    // 4: backpressure, B held while A is pending
    run(5);
    do_load(32'hA1B2_C3D4, 8'h81, 8'hF7, 1'b0);
    do_load(32'h0000_BEEF, 8'h10, 8'hFF, 1'b1);
    chk("bp_b_after_wrap", t % FRAME, 1);
    run(2 * FRAME + 10);

    // 5: accept exactly on the wrap edge with nothing pending
    to_wrap();
    load_data = 32'h1357_9BDF; load_dp = 8'h22; load_en = 8'hFF; load_lz = 1'b0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("wrap_acc_ready", load_ready, 1);
    clr_seen(); run(FRAME);
    chk("wrap_acc_dig0", seen[0], 8'h8E);

    // 6: reset during DIG_4 with a load pending
    while (t % FRAME != 0) step();
    do_load(32'h8888_8888, 8'hFF, 8'hFF, 1'b0);
    while (t % FRAME != 4 * DW + 3) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_sel", sel, 8'h00);
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_ready", load_ready, 1);
    clr_seen(); run(2 * FRAME + 5);
    for (int n = 0; n < 8; n++) chk($sformatf("midrst_dark%0d", n), seen[n], 8'hFF);

    // random loads at random points in the scan
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(0, 80));
      do_load($urandom, 8'($urandom), 8'($urandom), 1'($urandom));
      if (r % 2 == 0) do_load($urandom, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    run(2 * FRAME + 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan scheduler for the 8-digit, 8-segment common-anode display.
- Holds a 32-bit hex display value plus per-digit DP, enable and leading-zero-blank settings.
- Time-multiplexes one digit at a time and drives per-digit sel/seg to the hc595 serializer stage.
- New content is accepted through a valid/ready load port and committed only at a full-scan boundary, so no scan ever mixes old and new digits.

Parameters:
- DWELL, 50000: sclk cycles each digit stays selected (1 ms at 50 MHz); must be ≥ 4.
- BLANK_CYC, 500: cycles at the start of each dwell with all digits deselected (anti-ghosting); 0 ≤ BLANK_CYC < DWELL.
- CNT_W, 16: dwell counter width; must satisfy 2^CNT_W ≥ DWELL.

Ports:
- sclk  in  1  system clock, 50 MHz
- rst  in  1  reset; synchronous to sclk, active-high
- load_data  in  32  hex value; nibble n (bits 4n+3:4n) is shown on DIG_n
- load_dp  in  8  decimal point per digit; bit n = 1 lights DP on DIG_n
- load_en  in  8  digit enable; bit n = 0 forces DIG_n blank
- load_lz  in  1  1 = suppress leading zeros
- load_valid  in  1  load request
- load_ready  out  1  load can be accepted this cycle
- sel  out  8  digit select, one-hot active-high; bit n = DIG_n, all-zero = none
- seg  out  8  segments, active-low; bit order DP,G,F,E,D,C,B,A (bit 7 = DP)
- frame_tick  out  1  one-cycle pulse when the scan wraps from DIG_7 to DIG_0

Behaviour:
- Clock and reset: one clock, sclk. Reset rst is synchronous and active-high, evaluated only on the sclk rising edge.
- Reset values:
  - sel=8'h00, seg=8'hFF, frame_tick=0, load_ready=1.
  - Dwell counter=0, digit index=0.
  - Active and pending registers cleared; active load_en=0, so the display is dark.
  - Reset asserted mid-scan or mid-handshake discards any pending load.
- Dwell counter: counts 0..DWELL-1 and wraps.
  - tick = (counter == DWELL-1).
  - On tick, digit index advances 0→1→…→7→0.
- Wrap event: tick while index==7.
  - frame_tick is registered high for exactly the following cycle.
  - Pending content is committed to the active registers on that same edge.
- Handshake:
  - A load is accepted on any edge where load_valid && load_ready; all load_* inputs are captured into the pending registers and the pending flag is set.
  - load_ready = !pending, registered.
  - The pending flag clears at commit, and load_ready returns to 1 on the cycle after commit.
  - Simultaneous accept and wrap with no prior pending: the accepted data commits directly on that edge and pending stays 0.
  - load_valid while load_ready=0 has no effect; the requester must hold its data.
- Output generation (registered, 1-cycle latency from counter/index):
  - While counter < BLANK_CYC: sel=8'h00, seg=8'hFF.
  - Otherwise: sel = 1 << index, and seg is the decode of the active nibble for index.
- Segment decode, active-low, DP bit=1:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- Blanking:
  - Digit n is blank (seg=8'hFF) if en[n]=0.
  - Digit n is also blank if lz=1, n≠0, and every nibble from n up to 7 is zero. DIG_0 is never zero-suppressed.
  - DP on a zero-suppressed digit is still shown.
  - DP forced on clears seg bit 7 after the blank/decode step. A digit disabled by en shows no DP.
- sel stays one-hot or zero at all times; it never has two bits set.

Decomposition:
- Shared package seg_pkg holds:
  - Hex-to-7-segment active-low constants (SEG_0..SEG_F, SEG_BLANK=8'hFF).
  - The DP bit index (7).
  - The digit count (8).
- Natural sub-module: hex_to_caseg, a combinational nibble-to-seg decoder. It is reused by other display blocks.
- seg_scan_ctrl instantiates hex_to_caseg once and registers its output.

Test Plan:
All scenarios use DWELL=8, BLANK_CYC=2.
1. Reset: rst=1 for 3 cycles, then released → sel=00, seg=FF, load_ready=1. Display stays dark until the first commit, and frame_tick first appears 64 cycles after release.
2. Basic load: load 0x76543210, en=FF, dp=00, lz=0, then run to commit → over the next scan, dwell k shows sel=(1<<k) with seg C0,F9,A4,B0,99,92,82,F8 for k=0..7. Cycles 0-1 of each dwell show sel=00, seg=FF.
3. Leading-zero blanking: load 0x00000120, lz=1, dp=04 → DIG_7..3 seg=FF; DIG_2=79 (F9 with DP on); DIG_1=A4; DIG_0=C0. Loading 0x00000000 instead → only DIG_0 lit (C0).
4. Handshake backpressure: accept A, then hold load_valid with B → load_ready=0 until the cycle after the wrap. A is displayed for the whole next scan; B is accepted after that and commits at the following wrap.
5. Simultaneous accept and wrap: load_valid asserted on the wrap edge with nothing pending → data is displayed starting at DIG_0 of the new scan, and load_ready stays 1.
6. Reset mid-scan: rst pulsed during DIG_4 with a load pending → next cycle sel=00, seg=FF, load_ready=1, and the pending data is never displayed.
